// File: rtl/dmg_timer_pkg.sv
// rtl/dmg_timer_pkg.sv - shared register indices, state encoding and TAC decode for dmg_timer
package dmg_timer_pkg;

    localparam logic [1:0] REG_DIV  = 2'd0;
    localparam logic [1:0] REG_TIMA = 2'd1;
    localparam logic [1:0] REG_TMA  = 2'd2;
    localparam logic [1:0] REG_TAC  = 2'd3;

    localparam int WAIT_CLKS = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RELOAD
    } timer_state_t;

    function automatic logic [3:0] tac_bit(input logic [1:0] sel);
        case (sel)
            2'b00:   tac_bit = 4'd9;
            2'b01:   tac_bit = 4'd3;
            2'b10:   tac_bit = 4'd5;
            default: tac_bit = 4'd7;
        endcase
    endfunction

endpackage

// File: rtl/dmg_timer_div.sv
// rtl/dmg_timer_div.sv - free-running divider and TIMA tick edge detector
// TIMER_WRITE_GLITCH_EN lets DIV/TAC writes produce a falling-edge tick.
module dmg_timer_div
    import dmg_timer_pkg::*;
#(
    parameter logic [15:0] DIV_INIT = 16'h0000
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        div_wr,
    input  logic        tac_wr,
    input  logic [2:0]  tac_next,
    output logic [15:0] div16,
    output logic        tick
);

    logic [15:0] div_next;
    logic        tsig_next;
    logic        prev_tsig;

    // tsig is taken from post-edge divider/TAC so the tick lands on the same edge as the fall
    always_comb begin
        div_next  = div_wr ? 16'h0000 : div16 + 16'h0001;
        tsig_next = tac_next[2] & div_next[tac_bit(tac_next[1:0])];
    end

`ifdef TIMER_WRITE_GLITCH_EN
    logic unused_tac_wr;
    assign unused_tac_wr = tac_wr;
    assign tick = prev_tsig & ~tsig_next;
`else
    assign tick = prev_tsig & ~tsig_next & ~(div_wr | tac_wr);
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            div16     <= DIV_INIT;
            prev_tsig <= 1'b0;
        end else begin
            div16     <= div_next;
            prev_tsig <= tsig_next;
        end
    end

endmodule

// File: rtl/dmg_timer.sv
// rtl/dmg_timer.sv - DMG timer: DIV/TIMA/TMA/TAC registers, overflow reload and irq
// TIMER_WRITE_GLITCH_EN enables the DIV/TAC write tick quirk in dmg_timer_div.
module dmg_timer
    import dmg_timer_pkg::*;
#(
    parameter int          T_OUT    = 0,
    parameter logic [15:0] DIV_INIT = 16'h0000
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [1:0] addr,
    input  logic       cs,
    input  logic       wr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);

    logic [15:0]  div16;
    logic         tick;
    logic [7:0]   tima;
    logic [7:0]   tma;
    logic [2:0]   tac;
    logic [2:0]   tac_next;
    logic [1:0]   wait_cnt;
    timer_state_t state;

    logic wr_en, div_wr, tima_wr, tma_wr, tac_wr;

    // Output delay is a cell-model annotation only; the netlist is zero-delay.
    logic unused_t_out;
    assign unused_t_out = (T_OUT != 0);

    assign wr_en    = cs & wr;
    assign div_wr   = wr_en & (addr == REG_DIV);
    assign tima_wr  = wr_en & (addr == REG_TIMA);
    assign tma_wr   = wr_en & (addr == REG_TMA);
    assign tac_wr   = wr_en & (addr == REG_TAC);
    assign tac_next = tac_wr ? din[2:0] : tac;

    dmg_timer_div #(
        .DIV_INIT (DIV_INIT)
    ) u_div (
        .clk      (clk),
        .nreset   (nreset),
        .div_wr   (div_wr),
        .tac_wr   (tac_wr),
        .tac_next (tac_next),
        .div16    (div16),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tima     <= 8'h00;
            tma      <= 8'h00;
            tac      <= 3'b000;
            wait_cnt <= 2'd0;
            state    <= IDLE;
            irq      <= 1'b0;
        end else begin
            irq <= 1'b0;
            if (tma_wr) tma <= din;
            if (tac_wr) tac <= din[2:0];
            case (state)
                IDLE: begin
                    if (tima_wr) begin
                        tima <= din;
                    end else if (tick) begin
                        if (tima == 8'hFF) begin
                            tima     <= 8'h00;
                            wait_cnt <= 2'(WAIT_CLKS - 1);
                            state    <= WAIT;
                        end else begin
                            tima <= tima + 8'd1;
                        end
                    end
                end
                WAIT: begin
                    if (tima_wr) begin
                        tima  <= din;
                        state <= IDLE;
                    end else begin
                        if (tick) tima <= tima + 8'd1;
                        if (wait_cnt == 2'd0) begin
                            tima  <= tma_wr ? din : tma;
                            irq   <= 1'b1;
                            state <= RELOAD;
                        end else begin
                            wait_cnt <= wait_cnt - 2'd1;
                        end
                    end
                end
                RELOAD: begin
                    // TIMA writes are swallowed here; a TMA write still lands in TIMA
                    if (tma_wr) tima <= din;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dout = 8'hFF;
        if (cs) begin
            case (addr)
                REG_DIV:  dout = div16[15:8];
                REG_TIMA: dout = tima;
                REG_TMA:  dout = tma;
                default:  dout = {5'b11111, tac};
            endcase
        end
    end

endmodule
